pkt_byte_fifo: RTL and testbench

//  Single-clock, byte-streaming packet FIFO for the router input/output port buffers.

---
 rtl/pkt_byte_fifo.sv | 172 +++++++++++++++++
 tb/tb_pkt_byte_fifo.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pkt_byte_fifo
// Purpose  : Single-clock byte-streaming packet FIFO. It packs bytes into
//            WIDTH-byte entries, tracks packet boundaries, and unpacks the
//            entries back into a byte stream with rlast.
// Options  : FIFO_STATS_EN enables the 16-bit packet in/out counters.
// Revision : 1.0 - initial release
// ============================================================================
module pkt_byte_fifo #(
    parameter int DEPTH     = 4,
    parameter int WIDTH     = 11,
    parameter int UWIDTH    = 8,
    parameter int PTR_SZ    = 2,
    parameter int PTR_IN_SZ = 4,
    parameter int AF_LEVEL  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wvalid,
    output logic              wready,
    input  logic [UWIDTH-1:0] wdata,
    input  logic              wlast,
    output logic              rvalid,
    input  logic              rready,
    output logic [UWIDTH-1:0] rdata,
    output logic              rlast,
    output logic [PTR_SZ:0]   count,
    output logic              almost_full,
    output logic [15:0]       pkt_in_cnt,
    output logic [15:0]       pkt_out_cnt
);

    localparam logic [PTR_SZ:0]    c_depth     = (PTR_SZ+1)'(DEPTH);
    localparam logic [PTR_SZ:0]    c_af_level  = (PTR_SZ+1)'(AF_LEVEL);
    localparam logic [PTR_SZ:0]    c_cnt_one   = (PTR_SZ+1)'(1);
    localparam logic [PTR_SZ-1:0]  c_ptr_one   = PTR_SZ'(1);
    localparam logic [PTR_IN_SZ-1:0] c_idx_one = PTR_IN_SZ'(1);
    localparam logic [PTR_IN_SZ-1:0] c_idx_end = PTR_IN_SZ'(WIDTH - 1);

    // Storage: payload bytes, per-entry byte length and end-of-packet flag
    logic [UWIDTH-1:0]    r_mem  [DEPTH][WIDTH];
    logic [PTR_IN_SZ-1:0] r_len  [DEPTH];
    logic                 r_last [DEPTH];

    logic [PTR_SZ-1:0]    r_wptr;
    logic [PTR_SZ-1:0]    r_rptr;
    logic [PTR_IN_SZ-1:0] r_wbyte;
    logic [PTR_IN_SZ-1:0] r_rbyte;
    logic [PTR_SZ:0]      r_count;
    logic                 r_almost_full;

    logic                 w_wr_fire;
    logic                 w_wr_commit;
    logic                 w_rd_fire;
    logic                 w_rd_end;
    logic                 w_rd_pop;
    logic [PTR_SZ:0]      w_count_nxt;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign wready      = (r_count < c_depth);
    assign rvalid      = (r_count != '0);
    assign w_wr_fire   = wvalid & wready;
    assign w_wr_commit = w_wr_fire & (wlast | (r_wbyte == c_idx_end));

    assign w_rd_end    = (r_rbyte == (r_len[r_rptr] - c_idx_one));
    assign w_rd_fire   = rvalid & rready;
    assign w_rd_pop    = w_rd_fire & w_rd_end;

    assign rdata       = r_mem[r_rptr][r_rbyte];
    assign rlast       = rvalid & r_last[r_rptr] & w_rd_end;

    assign count       = r_count;
    assign almost_full = r_almost_full;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_commit, w_rd_pop})
            2'b10:   w_count_nxt = r_count + c_cnt_one;
            2'b01:   w_count_nxt = r_count - c_cnt_one;
            default: w_count_nxt = r_count;
        endcase
    end

    // ------------------------------------------------------------------
    // Storage writes; contents are intentionally left untouched by reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[r_wptr][r_wbyte] <= wdata;
        end
        if (w_wr_commit) begin
            r_len[r_wptr]  <= r_wbyte + c_idx_one;
            r_last[r_wptr] <= wlast;
        end
    end

    // ------------------------------------------------------------------
    // Write-side packing state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_wbyte <= '0;
        end else if (w_wr_commit) begin
            r_wptr  <= r_wptr + c_ptr_one;
            r_wbyte <= '0;
        end else if (w_wr_fire) begin
            r_wbyte <= r_wbyte + c_idx_one;
        end
    end

    // ------------------------------------------------------------------
    // Read-side unpacking state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rptr  <= '0;
            r_rbyte <= '0;
        end else if (w_rd_pop) begin
            r_rptr  <= r_rptr + c_ptr_one;
            r_rbyte <= '0;
        end else if (w_rd_fire) begin
            r_rbyte <= r_rbyte + c_idx_one;
        end
    end

    // ------------------------------------------------------------------
    // Occupancy and almost-full, registered for the arbiter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count       <= '0;
            r_almost_full <= 1'b0;
        end else begin
            r_count       <= w_count_nxt;
            r_almost_full <= (w_count_nxt >= c_af_level);
        end
    end

    // ------------------------------------------------------------------
    // Optional packet statistics
    // ------------------------------------------------------------------
`ifdef FIFO_STATS_EN
    logic [15:0] r_pkt_in_cnt;
    logic [15:0] r_pkt_out_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pkt_in_cnt  <= '0;
            r_pkt_out_cnt <= '0;
        end else begin
            if (w_wr_commit && wlast) begin
                r_pkt_in_cnt <= r_pkt_in_cnt + 16'd1;
            end
            if (w_rd_pop && r_last[r_rptr]) begin
                r_pkt_out_cnt <= r_pkt_out_cnt + 16'd1;
            end
        end
    end

    assign pkt_in_cnt  = r_pkt_in_cnt;
    assign pkt_out_cnt = r_pkt_out_cnt;
`else
    assign pkt_in_cnt  = 16'd0;
    assign pkt_out_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pkt_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_byte_fifo
// Purpose  : Self-checking bench for pkt_byte_fifo (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_byte_fifo;

    localparam int DEPTH = 4;
    localparam int WIDTH = 11;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wvalid = 1'b0;
    logic       wready;
    logic [7:0] wdata = 8'h00;
    logic       wlast = 1'b0;
    logic       rvalid;
    logic       rready = 1'b0;
    logic [7:0] rdata;
    logic       rlast;
    logic [2:0] count;
    logic       almost_full;
    logic [15:0] pkt_in_cnt;
    logic [15:0] pkt_out_cnt;

    pkt_byte_fifo #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .UWIDTH(8),
        .PTR_SZ(2), .PTR_IN_SZ(4), .AF_LEVEL(3)
    ) u_dut (
        .clk(clk), .rst(rst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast),
        .count(count), .almost_full(almost_full),
        .pkt_in_cnt(pkt_in_cnt), .pkt_out_cnt(pkt_out_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } sb_item_t;

    typedef struct {
        int         len;
        logic [7:0] first;
        int         exp_count;
        logic       exp_af;
    } vec_t;

    sb_item_t sb_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    int exp_pkt_in  = 0;
    int exp_pkt_out = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic put_byte(input logic [7:0] d, input logic l);
        int waited = 0;
        wvalid = 1'b1;
        wdata  = d;
        wlast  = l;
        while (!wready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("wready_timeout", {31'd0, wready}, 32'd1);
        @(negedge clk);
        wvalid = 1'b0;
        wlast  = 1'b0;
        sb_q.push_back({d, l});
        if (l) exp_pkt_in++;
    endtask

    task automatic put_pkt(input int len, input logic [7:0] first);
        for (int i = 0; i < len; i++) begin
            put_byte(first + 8'(i), (i == len - 1));
        end
    endtask

    // Called at a negedge; compares the byte presented, then consumes it.
    task automatic get_byte();
        int waited = 0;
        sb_item_t exp;
        rready = 1'b1;
        while (!rvalid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("rvalid_timeout", {31'd0, rvalid}, 32'd1);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            exp = sb_q.pop_front();
            check("rdata", {24'd0, rdata}, {24'd0, exp.data});
            check("rlast", {31'd0, rlast}, {31'd0, exp.last});
            if (exp.last) exp_pkt_out++;
        end
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic drain();
        while (sb_q.size() != 0) get_byte();
        check("count_after_drain", {29'd0, count}, 32'd0);
        check("rvalid_after_drain", {31'd0, rvalid}, 32'd0);
    endtask

    task automatic check_stats(input string tag);
`ifdef FIFO_STATS_EN
        check({tag, "_pkt_in"},  {16'd0, pkt_in_cnt},  exp_pkt_in);
        check({tag, "_pkt_out"}, {16'd0, pkt_out_cnt}, exp_pkt_out);
`else
        check({tag, "_pkt_in"},  {16'd0, pkt_in_cnt},  32'd0);
        check({tag, "_pkt_out"}, {16'd0, pkt_out_cnt}, 32'd0);
`endif
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{len: 1,  first: 8'h10, exp_count: 1, exp_af: 1'b0};
        vecs[1] = '{len: 11, first: 8'h00, exp_count: 1, exp_af: 1'b0};
        vecs[2] = '{len: 12, first: 8'h20, exp_count: 2, exp_af: 1'b0};
        vecs[3] = '{len: 25, first: 8'h40, exp_count: 3, exp_af: 1'b1};
        vecs[4] = '{len: 22, first: 8'h60, exp_count: 2, exp_af: 1'b0};
        vecs[5] = '{len: 44, first: 8'h80, exp_count: 4, exp_af: 1'b1};
        vecs[6] = '{len: 5,  first: 8'hC0, exp_count: 1, exp_af: 1'b0};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_wready", {31'd0, wready}, 32'd1);
        check("rst_af", {31'd0, almost_full}, 32'd0);
        check("rst_rlast", {31'd0, rlast}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_stats("rst");

        // Table-driven packets: occupancy after write, then ordered readback
        for (int v = 0; v < 7; v++) begin
            put_pkt(vecs[v].len, vecs[v].first);
            check($sformatf("vec%0d_count", v), {29'd0, count}, vecs[v].exp_count);
            check($sformatf("vec%0d_af", v), {31'd0, almost_full}, {31'd0, vecs[v].exp_af});
            check($sformatf("vec%0d_wready", v), {31'd0, wready},
                  (vecs[v].exp_count < DEPTH) ? 32'd1 : 32'd0);
            drain();
        end

        // Reset while a packet is half-packed discards everything
        put_pkt(1, 8'h33);
        for (int i = 0; i < 5; i++) put_byte(8'hE0 + 8'(i), 1'b0);
        for (int i = 0; i < 5; i++) void'(sb_q.pop_back());
        check("pre_rst_count", {29'd0, count}, 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_count", {29'd0, count}, 32'd0);
        check("midrst_rvalid", {31'd0, rvalid}, 32'd0);
        check("midrst_wready", {31'd0, wready}, 32'd1);
        sb_q.delete();
        exp_pkt_in  = 0;
        exp_pkt_out = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        put_pkt(1, 8'h55);
        drain();

        // Full FIFO holds off the fifth write until one pop
        for (int i = 0; i < 4; i++) put_pkt(1, 8'hA1 + 8'(i));
        check("full_count", {29'd0, count}, 32'd4);
        check("full_wready", {31'd0, wready}, 32'd0);
        check("full_af", {31'd0, almost_full}, 32'd1);
        wvalid = 1'b1;
        wdata  = 8'hA5;
        wlast  = 1'b1;
        repeat (3) @(negedge clk);
        check("full_hold_count", {29'd0, count}, 32'd4);
        begin
            sb_item_t exp;
            exp = sb_q.pop_front();
            rready = 1'b1;
            check("full_pop_rdata", {24'd0, rdata}, {24'd0, exp.data});
            check("full_pop_rlast", {31'd0, rlast}, {31'd0, exp.last});
            exp_pkt_out++;
        end
        @(negedge clk);
        rready = 1'b0;
        check("after_pop_count", {29'd0, count}, 32'd3);
        check("after_pop_wready", {31'd0, wready}, 32'd1);
        @(negedge clk);
        wvalid = 1'b0;
        wlast  = 1'b0;
        sb_q.push_back({8'hA5, 1'b1});
        exp_pkt_in++;
        check("resume_count", {29'd0, count}, 32'd4);
        drain();

        // Simultaneous commit and pop keeps count, pointers wrap
        put_pkt(1, 8'hB0);
        put_pkt(1, 8'hB1);
        check("pair_count", {29'd0, count}, 32'd2);
        for (int i = 0; i < 6; i++) begin
            sb_item_t exp;
            exp = sb_q.pop_front();
            wvalid = 1'b1;
            wdata  = 8'hB2 + 8'(i);
            wlast  = 1'b1;
            rready = 1'b1;
            check($sformatf("both%0d_rdata", i), {24'd0, rdata}, {24'd0, exp.data});
            @(negedge clk);
            wvalid = 1'b0;
            wlast  = 1'b0;
            rready = 1'b0;
            sb_q.push_back({8'hB2 + 8'(i), 1'b1});
            exp_pkt_in++;
            exp_pkt_out++;
            check($sformatf("both%0d_count", i), {29'd0, count}, 32'd2);
        end
        drain();

        // Statistics: three packets in, two fully read
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        exp_pkt_in  = 0;
        exp_pkt_out = 0;
        @(negedge clk);
        put_pkt(3, 8'h01);
        put_pkt(13, 8'h11);
        put_pkt(2, 8'h31);
        for (int i = 0; i < 16; i++) get_byte();
        check_stats("stats");
        drain();
        check_stats("stats_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
